vga_timing_gen: RTL

- Generates the raster scan that drives every sprite and background renderer: DrawX/DrawY pixel coordinates, the active-high blank (visible) qualifier, and HS/VS sync.
- Sits directly upstream of the sprite ROM/palette stages, which sample DrawX/DrawY/blank on vga_clk.
- Also emits line, frame and vblank strobes plus a frame counter, so game logic can update sprite positions and animation frames during vertical blanking.

---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster scan counter with registered sync, blank and frame strobes
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       ce,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       sync,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       line_end,
   output logic       frame_end,
   output logic       vblank_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   // DrawX/DrawY are the h/v counters themselves.
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       wrap;
   logic       blank_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       line_end_nxt;
   logic       frame_end_nxt;
   logic       vblank_start_nxt;

   always_comb begin
      h_nxt = DrawX;
      v_nxt = DrawY;
      wrap  = 1'b0;
      if (DrawX == H_LAST) begin
         h_nxt = '0;
         if (DrawY == V_LAST) begin
            v_nxt = '0;
            wrap  = 1'b1;
         end else begin
            v_nxt = DrawY + 10'd1;
         end
      end else begin
         h_nxt = DrawX + 10'd1;
      end
   end

   // Decode the position being entered so registered outputs line up with DrawX/DrawY.
   always_comb begin
      blank_nxt        = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hs_nxt           = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_nxt           = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_end_nxt     = (h_nxt == H_LAST);
      frame_end_nxt    = (h_nxt == H_LAST) && (v_nxt == V_LAST);
      vblank_start_nxt = (h_nxt == '0) && (v_nxt == V_VIS);
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         DrawX        <= '0;
         DrawY        <= '0;
         frame_count  <= '0;
         hs           <= ~SYNC_POL;
         vs           <= ~SYNC_POL;
         blank        <= 1'b0;
         line_end     <= 1'b0;
         frame_end    <= 1'b0;
         vblank_start <= 1'b0;
      end else if (ce) begin
         DrawX        <= h_nxt;
         DrawY        <= v_nxt;
         hs           <= hs_nxt;
         vs           <= vs_nxt;
         blank        <= blank_nxt;
         line_end     <= line_end_nxt;
         frame_end    <= frame_end_nxt;
         vblank_start <= vblank_start_nxt;
         if (wrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   assign sync = 1'b0;

endmodule
